// File: rtl/core_pkg.sv
// Shared types and helpers for the memory-access stage: access sizes, FSM states,
// and lane/byte-enable arithmetic used by the request path.
package core_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } memacc_state_e;

    // Widest bus supported is 64 bits, so eight byte lanes.
    localparam int unsigned MAX_BE_W = 8;

    function automatic logic [MAX_BE_W-1:0] calc_be(input logic [1:0] size, input logic [2:0] lane);
        logic [3:0]  nbytes;
        logic [15:0] mask;
        nbytes = 4'd1 << size;
        mask   = ((16'd1 << nbytes) - 16'd1) << lane;
        return mask[MAX_BE_W-1:0];
    endfunction

    // Lane bits that must be zero for an access of the given size to be aligned.
    function automatic logic [2:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        m = (4'd1 << size) - 4'd1;
        return m[2:0];
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load data aligner: shifts the addressed lane down to bit 0,
// truncates to the access size and sign- or zero-extends to XLEN.
module load_align_ext
    import core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int LANE_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]   rdata,
    input  logic [LANE_W-1:0] lane,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [XLEN-1:0]   result
);

    localparam int IDX_W = $clog2(XLEN);

    logic [XLEN-1:0] shifted;
    int unsigned     nbits;
    logic            fill;

    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        case (mem_size_e'(size))
            SZ_B:    nbits = 8;
            SZ_H:    nbits = 16;
            SZ_W:    nbits = 32;
            default: nbits = XLEN;
        endcase
        fill   = !is_unsigned && shifted[IDX_W'(nbits - 1)];
        result = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            result[i] = (i < nbits) ? shifted[i] : fill;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/gnt + rvalid bus and
// passes non-memory results through. Optional misaligned trap: MEMACC_MISALIGN_TRAP_EN.
module mem_access_stage
    import core_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_is_mem,
    input  logic                 in_is_store,
    input  logic [1:0]           in_size,
    input  logic                 in_unsigned,
    input  logic [XLEN-1:0]      in_addr,
    input  logic [XLEN-1:0]      in_store_data,
    input  logic [XLEN-1:0]      in_rd_data,
    input  logic [REG_IDX_W-1:0] in_rd_idx,
    input  logic                 in_wb_en,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [XLEN-1:0]      dmem_addr,
    output logic [XLEN/8-1:0]    dmem_be,
    output logic [XLEN-1:0]      dmem_wdata,
    input  logic                 dmem_gnt,
    input  logic                 dmem_rvalid,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_wb_en,
    output logic [REG_IDX_W-1:0] out_rd_idx,
    output logic [XLEN-1:0]      out_rd_data,
    output logic                 out_exc,
    output logic [XLEN-1:0]      out_exc_addr
);

    localparam int BE_W   = XLEN / 8;
    localparam int LANE_W = $clog2(BE_W);

    memacc_state_e state, state_n;

    logic [1:0]           size_c;
    logic [LANE_W-1:0]    lane_raw;
    logic [LANE_W-1:0]    align_mask;
    logic [LANE_W-1:0]    lane_c;
    logic                 misaligned;
    logic [XLEN-1:0]      wdata_c;
    logic                 accept;

    logic [LANE_W-1:0]    lane_q;
    logic [1:0]           size_q;
    logic                 uns_q;
    logic [REG_IDX_W-1:0] rd_idx_q;
    logic                 wb_en_q;
    logic [XLEN-1:0]      load_ext;

    // Dword is only meaningful on a 64-bit bus; narrower buses clamp to their width.
    always_comb begin
        size_c     = (in_size > 2'(LANE_W)) ? 2'(LANE_W) : in_size;
        lane_raw   = in_addr[LANE_W-1:0];
        align_mask = LANE_W'(size_mask(size_c));
`ifdef MEMACC_MISALIGN_TRAP_EN
        misaligned = in_is_mem && |(lane_raw & align_mask);
        lane_c     = lane_raw;
`else
        misaligned = 1'b0;
        lane_c     = lane_raw & ~align_mask;
`endif
        wdata_c    = in_store_data << {lane_c, 3'b000};
    end

    assign in_ready = ((state == IDLE) || (state == HOLD)) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign dmem_req = (state == REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, HOLD: begin
                if (accept) begin
                    if (!in_is_mem)     state_n = IDLE;
                    else if (misaligned) state_n = HOLD;
                    else                state_n = REQ;
                end else if (out_valid && out_ready) begin
                    state_n = IDLE;
                end
            end
            REQ:     if (dmem_gnt)    state_n = dmem_we ? HOLD : WAIT;
            WAIT:    if (dmem_rvalid) state_n = HOLD;
            default: state_n = IDLE;
        endcase
    end

    load_align_ext #(
        .XLEN   (XLEN),
        .LANE_W (LANE_W)
    ) u_load_ext (
        .rdata       (dmem_rdata),
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (load_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            out_valid    <= 1'b0;
            out_wb_en    <= 1'b0;
            out_rd_idx   <= '0;
            out_rd_data  <= '0;
`ifdef MEMACC_MISALIGN_TRAP_EN
            out_exc      <= 1'b0;
            out_exc_addr <= '0;
`endif
            lane_q       <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            rd_idx_q     <= '0;
            wb_en_q      <= 1'b0;
        end else begin
            // Retire first; a result produced in the same cycle overrides below.
            if (out_valid && out_ready) out_valid <= 1'b0;

            if (accept) begin
                lane_q   <= lane_c;
                size_q   <= size_c;
                uns_q    <= in_unsigned;
                rd_idx_q <= in_rd_idx;
                wb_en_q  <= in_wb_en;
                if (!in_is_mem) begin
                    out_valid   <= 1'b1;
                    out_wb_en   <= in_wb_en;
                    out_rd_idx  <= in_rd_idx;
                    out_rd_data <= in_rd_data;
`ifdef MEMACC_MISALIGN_TRAP_EN
                    out_exc     <= 1'b0;
`endif
                end else if (misaligned) begin
                    out_valid    <= 1'b1;
                    out_wb_en    <= 1'b0;
                    out_rd_idx   <= in_rd_idx;
                    out_rd_data  <= '0;
`ifdef MEMACC_MISALIGN_TRAP_EN
                    out_exc      <= 1'b1;
                    out_exc_addr <= in_addr;
`endif
                end else begin
                    dmem_we    <= in_is_store;
                    dmem_addr  <= {in_addr[XLEN-1:LANE_W], {LANE_W{1'b0}}};
                    dmem_be    <= BE_W'(calc_be(size_c, 3'(lane_c)));
                    dmem_wdata <= wdata_c;
                end
            end

            if (state == REQ && dmem_gnt && dmem_we) begin
                out_valid   <= 1'b1;
                out_wb_en   <= 1'b0;
                out_rd_idx  <= rd_idx_q;
                out_rd_data <= '0;
`ifdef MEMACC_MISALIGN_TRAP_EN
                out_exc     <= 1'b0;
`endif
            end

            if (state == WAIT && dmem_rvalid) begin
                out_valid   <= 1'b1;
                out_wb_en   <= wb_en_q;
                out_rd_idx  <= rd_idx_q;
                out_rd_data <= load_ext;
`ifdef MEMACC_MISALIGN_TRAP_EN
                out_exc     <= 1'b0;
`endif
            end
        end
    end

`ifndef MEMACC_MISALIGN_TRAP_EN
    assign out_exc      = 1'b0;
    assign out_exc_addr = '0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table plus hand-written
// back-pressure and reset sequences, results checked through a scoreboard queue.
module tb_mem_access_stage;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int BW   = XLEN / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, in_is_mem, in_is_store, in_unsigned, in_wb_en;
    logic [1:0]      in_size;
    logic [XLEN-1:0] in_addr, in_store_data, in_rd_data;
    logic [RW-1:0]   in_rd_idx;
    logic            dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [BW-1:0]   dmem_be;
    logic            out_valid, out_ready, out_wb_en, out_exc;
    logic [RW-1:0]   out_rd_idx;
    logic [XLEN-1:0] out_rd_data, out_exc_addr;

    always #5 clk = ~clk;

    mem_access_stage #(.XLEN(XLEN), .REG_IDX_W(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_mem(in_is_mem), .in_is_store(in_is_store),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_store_data(in_store_data),
        .in_rd_data(in_rd_data), .in_rd_idx(in_rd_idx), .in_wb_en(in_wb_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_wb_en(out_wb_en), .out_rd_idx(out_rd_idx),
        .out_rd_data(out_rd_data), .out_exc(out_exc), .out_exc_addr(out_exc_addr)
    );

    typedef struct {
        logic            is_mem, is_store;
        logic [1:0]      size;
        logic            uns;
        logic [XLEN-1:0] addr, sdata, rdv, rdata;
        logic [RW-1:0]   rd;
        logic            wb;
        int unsigned     gdly;
        logic            noreq;
        logic [XLEN-1:0] e_addr;
        logic [BW-1:0]   e_be;
        logic [XLEN-1:0] e_wdata, e_data;
        logic            e_wb, e_chk, e_exc;
        logic [XLEN-1:0] e_exc_addr;
    } vec_t;

    typedef struct {
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            wb, chk, exc;
        logic [XLEN-1:0] exc_addr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[12];
    vec_t v;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("out_rd_idx", out_rd_idx, mon_e.rd);
                check("out_wb_en", out_wb_en, mon_e.wb);
                check("out_exc", out_exc, mon_e.exc);
                if (mon_e.chk) check("out_rd_data", out_rd_data, mon_e.data);
                if (mon_e.exc) check("out_exc_addr", out_exc_addr, mon_e.exc_addr);
            end
        end
    end

    task automatic drive(input vec_t d, input bit push);
        exp_t e;
        in_valid = 1'b1;  in_is_mem = d.is_mem;  in_is_store = d.is_store;
        in_size = d.size; in_unsigned = d.uns;   in_addr = d.addr;
        in_store_data = d.sdata; in_rd_data = d.rdv; in_rd_idx = d.rd; in_wb_en = d.wb;
        if (push) begin
            e.rd = d.rd; e.data = d.e_data; e.wb = d.e_wb; e.chk = d.e_chk;
            e.exc = d.e_exc; e.exc_addr = d.e_exc_addr;
            sb.push_back(e);
        end
    endtask

    task automatic wait_accept();
        int unsigned n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (n >= 50) check("accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic serve(input vec_t d);
        int unsigned reqc = 0;
        if (!d.is_mem) begin
            check("nonmem_no_req", dmem_req, 0);
        end else if (d.noreq) begin
            check("trap_no_req", dmem_req, 0);
        end else begin
            check("dmem_req", dmem_req, 1);
            check("dmem_addr", dmem_addr, d.e_addr);
            check("dmem_be", dmem_be, d.e_be);
            check("dmem_wdata", dmem_wdata, d.e_wdata);
            check("dmem_we", dmem_we, d.is_store);
            for (int unsigned i = 0; i < d.gdly; i++) begin
                if (dmem_req && dmem_addr == d.e_addr && dmem_be == d.e_be && dmem_wdata == d.e_wdata) reqc++;
                tick();
            end
            if (dmem_req && dmem_addr == d.e_addr && dmem_be == d.e_be) reqc++;
            dmem_gnt = 1'b1;
            tick();
            dmem_gnt = 1'b0;
            check("req_held_cycles", reqc, d.gdly + 1);
            if (!d.is_store) begin
                check("no_req_in_wait", dmem_req, 0);
                check("in_ready_wait", in_ready, 0);
                dmem_rvalid = 1'b1;
                dmem_rdata  = d.rdata;
                tick();
                dmem_rvalid = 1'b0;
                dmem_rdata  = 32'h5A5A5A5A;
            end
        end
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 20) begin tick(); n++; end
        if (n >= 20) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_is_mem = 1'b0; in_is_store = 1'b0; in_size = 2'd0;
        in_unsigned = 1'b0; in_addr = '0; in_store_data = '0; in_rd_data = '0; in_rd_idx = '0;
        in_wb_en = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; out_ready = 1'b1;

        //           mem st sz u  addr          sdata          rdv            rdata          rd wb dly nrq e_addr        e_be     e_wdata        e_data         ewb chk exc exc_addr
        vt[0]  = '{1'b0,1'b0,2'd0,1'b0, 32'h0,     32'h0,        32'hDEADBEEF, 32'h0,        5'd5, 1'b1,0,1'b0, 32'h0,     4'b0000, 32'h0,        32'hDEADBEEF, 1'b1,1'b1,1'b0,32'h0};
        vt[1]  = '{1'b1,1'b0,2'd0,1'b0, 32'h1003,  32'h0,        32'h0,        32'h80AABBCC, 5'd7, 1'b1,0,1'b0, 32'h1000,  4'b1000, 32'h0,        32'hFFFFFF80, 1'b1,1'b1,1'b0,32'h0};
        vt[2]  = '{1'b1,1'b1,2'd1,1'b0, 32'h2002,  32'h1234,     32'h0,        32'h0,        5'd3, 1'b1,3,1'b0, 32'h2000,  4'b1100, 32'h12340000, 32'h0,        1'b0,1'b0,1'b0,32'h0};
        vt[3]  = '{1'b1,1'b0,2'd1,1'b1, 32'h3002,  32'h0,        32'h0,        32'h80017FFF, 5'd8, 1'b1,1,1'b0, 32'h3000,  4'b1100, 32'h0,        32'h00008001, 1'b1,1'b1,1'b0,32'h0};
        vt[4]  = '{1'b1,1'b0,2'd1,1'b0, 32'h3000,  32'h0,        32'h0,        32'h12348765, 5'd9, 1'b1,0,1'b0, 32'h3000,  4'b0011, 32'h0,        32'hFFFF8765, 1'b1,1'b1,1'b0,32'h0};
        vt[5]  = '{1'b1,1'b0,2'd0,1'b1, 32'h4001,  32'h0,        32'h0,        32'h0000F000, 5'd10,1'b1,2,1'b0, 32'h4000,  4'b0010, 32'h0,        32'h000000F0, 1'b1,1'b1,1'b0,32'h0};
        vt[6]  = '{1'b1,1'b1,2'd0,1'b0, 32'h5001,  32'hAB,       32'h0,        32'h0,        5'd11,1'b1,1,1'b0, 32'h5000,  4'b0010, 32'h0000AB00, 32'h0,        1'b0,1'b0,1'b0,32'h0};
        vt[7]  = '{1'b1,1'b1,2'd2,1'b0, 32'h6004,  32'hCAFEF00D, 32'h0,        32'h0,        5'd12,1'b1,0,1'b0, 32'h6004,  4'b1111, 32'hCAFEF00D, 32'h0,        1'b0,1'b0,1'b0,32'h0};
        vt[8]  = '{1'b0,1'b0,2'd0,1'b0, 32'h0,     32'h0,        32'h12345678, 32'h0,        5'd0, 1'b0,0,1'b0, 32'h0,     4'b0000, 32'h0,        32'h12345678, 1'b0,1'b1,1'b0,32'h0};
        vt[9]  = '{1'b1,1'b0,2'd0,1'b0, 32'h9000,  32'h0,        32'h0,        32'h0000007F, 5'd14,1'b0,0,1'b0, 32'h9000,  4'b0001, 32'h0,        32'h0000007F, 1'b0,1'b1,1'b0,32'h0};
`ifdef MEMACC_MISALIGN_TRAP_EN
        vt[10] = '{1'b1,1'b0,2'd2,1'b0, 32'h1001,  32'h0,        32'h0,        32'h11223344, 5'd13,1'b1,0,1'b1, 32'h0,     4'b0000, 32'h0,        32'h0,        1'b0,1'b0,1'b1,32'h1001};
        vt[11] = '{1'b1,1'b1,2'd1,1'b0, 32'h2003,  32'hAA,       32'h0,        32'h0,        5'd15,1'b1,0,1'b1, 32'h0,     4'b0000, 32'h0,        32'h0,        1'b0,1'b0,1'b1,32'h2003};
`else
        vt[10] = '{1'b1,1'b0,2'd2,1'b0, 32'h1001,  32'h0,        32'h0,        32'h11223344, 5'd13,1'b1,0,1'b0, 32'h1000,  4'b1111, 32'h0,        32'h11223344, 1'b1,1'b1,1'b0,32'h0};
        vt[11] = '{1'b1,1'b1,2'd1,1'b0, 32'h2003,  32'hAA,       32'h0,        32'h0,        5'd15,1'b1,0,1'b0, 32'h2000,  4'b1100, 32'h00AA0000, 32'h0,        1'b0,1'b0,1'b0,32'h0};
`endif

        tick(); tick();
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_dmem_be", dmem_be, 0);
        check("rst_dmem_addr", dmem_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_wb_en", out_wb_en, 0);
        check("rst_out_exc", out_exc, 0);
        check("rst_out_rd_data", out_rd_data, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        for (int unsigned k = 0; k < 12; k++) begin
            drive(vt[k], 1'b1);
            wait_accept();
            serve(vt[k]);
            drain();
        end

        // Back-pressure: result held for five cycles while a second op waits.
        v = vt[4];
        v.addr = 32'h8000; v.size = 2'd2; v.rd = 5'd9; v.rdata = 32'h0BADF00D;
        v.e_addr = 32'h8000; v.e_be = 4'b1111; v.e_data = 32'h0BADF00D;
        out_ready = 1'b0;
        drive(v, 1'b1);
        wait_accept();
        serve(v);
        v = vt[0];
        v.rd = 5'd10; v.rdv = 32'h00C0FFEE; v.e_data = 32'h00C0FFEE;
        drive(v, 1'b1);
        for (int unsigned i = 0; i < 5; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_rd_data", out_rd_data, 32'h0BADF00D);
            check("bp_in_ready", in_ready, 0);
            check("bp_no_req", dmem_req, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_accept_on_retire", in_ready, 1);
        tick();
        in_valid = 1'b0;
        drain();

        // Reset during REQ: the request must drop without waiting for a clock edge.
        v = vt[4];
        v.addr = 32'h7000; v.size = 2'd2;
        drive(v, 1'b0);
        wait_accept();
        check("pre_rst_req", dmem_req, 1);
        #2 rst = 1'b1;
        #1;
        check("async_req_drop", dmem_req, 0);
        check("async_be_clear", dmem_be, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_req_idle", dmem_req, 0);
        check("post_rst_in_ready_req", in_ready, 1);

        // Reset during WAIT: a later rvalid must be ignored.
        v.addr = 32'h7004;
        drive(v, 1'b0);
        wait_accept();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        check("wait_in_ready", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h55555555;
        tick();
        dmem_rvalid = 1'b0;
        tick();
        check("rst_wait_out_valid", out_valid, 0);
        check("rst_wait_out_rd_data", out_rd_data, 0);
        check("rst_wait_in_ready", in_ready, 1);
        check("rst_wait_no_req", dmem_req, 0);
        check("rst_wait_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
